// File: rtl/tic_tac_toe_nk_if.sv
// Pushbutton/LED side of the NxN game engine: button inputs, turn/result
// flags, per-cell mark LEDs and per-player score counters.
interface tic_tac_toe_nk_if #(
  parameter int N       = 3,
  parameter int SCORE_W = 4
);
  logic [N*N-1:0]     btn;
  logic               new_game;
  logic               p1_turn;
  logic               p2_turn;
  logic               p1_win;
  logic               p2_win;
  logic               grid_full;
  logic [N*N-1:0]     cell_p1;
  logic [N*N-1:0]     cell_p2;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;

  modport master (
    output btn, new_game,
    input  p1_turn, p2_turn, p1_win, p2_win, grid_full,
    input  cell_p1, cell_p2, p1_score, p2_score
  );

  modport slave (
    input  btn, new_game,
    output p1_turn, p2_turn, p1_win, p2_win, grid_full,
    output cell_p1, cell_p2, p1_score, p2_score
  );
endinterface

// File: rtl/tic_tac_toe_nk.sv
// NxN, K-in-a-row two-player game engine with synchronised, edge-detected
// buttons, new_game restart with alternating starter and saturating scores.
module tic_tac_toe_nk #(
  parameter int N       = 3,
  parameter int K       = 3,
  parameter int SCORE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  tic_tac_toe_nk_if.slave  bus
);

  localparam int CELLS = N * N;

  typedef enum logic [2:0] {
    P1_MOVE, P2_MOVE, CHECK, P1_WON, P2_WON, DRAW
  } state_t;

  state_t             state, state_nx;
  logic [CELLS-1:0]   btn_s1, btn_s2, press;
  logic               ng_s1, ng_s2, ng_press;
  logic [CELLS-1:0]   cell_p1, cell_p2, cell_p1_nx, cell_p2_nx, occupied;
  logic               starter_p2, starter_p2_nx, mover_p2, mover_p2_nx;
  logic               p1_win, p2_win, grid_full;
  logic               p1_win_nx, p2_win_nx, grid_full_nx;
  logic [SCORE_W-1:0] p1_score, p2_score, p1_score_nx, p2_score_nx;
  logic               one_hot, line_p1, line_p2, mover_line;

  // Scans every window of K cells along rows, columns and both diagonals.
  // Indices are reduced modulo CELLS so disabled windows never read out of range.
  function automatic logic has_line(input logic [CELLS-1:0] m);
    logic             hit, run_r, run_c, run_d, run_a;
    logic [CELLS-1:0] sh;
    hit = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        run_r = (c + K <= N);
        run_c = (r + K <= N);
        run_d = run_r && run_c;
        run_a = run_c && (c >= K - 1);
        for (int i = 0; i < K; i++) begin
          sh = m >> ((r * N + c + i) % CELLS);
          run_r = run_r & sh[0];
          sh = m >> (((r + i) * N + c) % CELLS);
          run_c = run_c & sh[0];
          sh = m >> (((r + i) * N + c + i) % CELLS);
          run_d = run_d & sh[0];
          sh = m >> (((r + i) * N + c - i) % CELLS);
          run_a = run_a & sh[0];
        end
        hit = hit | run_r | run_c | run_d | run_a;
      end
    end
    return hit;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

  assign press      = btn_s1 & ~btn_s2;
  assign ng_press   = ng_s1 & ~ng_s2;
  assign occupied   = cell_p1 | cell_p2;
  assign one_hot    = (press != '0) && ((press & (press - CELLS'(1))) == '0);
  assign line_p1    = has_line(cell_p1);
  assign line_p2    = has_line(cell_p2);
  assign mover_line = mover_p2 ? line_p2 : line_p1;

  always_comb begin
    state_nx      = state;
    cell_p1_nx    = cell_p1;
    cell_p2_nx    = cell_p2;
    starter_p2_nx = starter_p2;
    mover_p2_nx   = mover_p2;
    p1_win_nx     = p1_win;
    p2_win_nx     = p2_win;
    grid_full_nx  = grid_full;
    p1_score_nx   = p1_score;
    p2_score_nx   = p2_score;
    // A restart overrides whatever move may have arrived on the same edge.
    if (ng_press) begin
      cell_p1_nx    = '0;
      cell_p2_nx    = '0;
      p1_win_nx     = 1'b0;
      p2_win_nx     = 1'b0;
      grid_full_nx  = 1'b0;
      starter_p2_nx = ~starter_p2;
      state_nx      = starter_p2 ? P1_MOVE : P2_MOVE;
    end else begin
      case (state)
        P1_MOVE, P2_MOVE: begin
          if (one_hot && ((press & occupied) == '0)) begin
            if (state == P1_MOVE) cell_p1_nx = cell_p1 | press;
            else                  cell_p2_nx = cell_p2 | press;
            mover_p2_nx = (state == P2_MOVE);
            state_nx    = CHECK;
          end
        end
        CHECK: begin
          if (mover_line) begin
            if (mover_p2) begin
              p2_win_nx   = 1'b1;
              p2_score_nx = sat_inc(p2_score);
              state_nx    = P2_WON;
            end else begin
              p1_win_nx   = 1'b1;
              p1_score_nx = sat_inc(p1_score);
              state_nx    = P1_WON;
            end
          end else if (&occupied) begin
            grid_full_nx = 1'b1;
            state_nx     = DRAW;
          end else begin
            state_nx = mover_p2 ? P1_MOVE : P2_MOVE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1     <= '0;
      btn_s2     <= '0;
      ng_s1      <= 1'b0;
      ng_s2      <= 1'b0;
      state      <= P1_MOVE;
      cell_p1    <= '0;
      cell_p2    <= '0;
      starter_p2 <= 1'b0;
      mover_p2   <= 1'b0;
      p1_win     <= 1'b0;
      p2_win     <= 1'b0;
      grid_full  <= 1'b0;
      p1_score   <= '0;
      p2_score   <= '0;
    end else begin
      btn_s1     <= bus.btn;
      btn_s2     <= btn_s1;
      ng_s1      <= bus.new_game;
      ng_s2      <= ng_s1;
      state      <= state_nx;
      cell_p1    <= cell_p1_nx;
      cell_p2    <= cell_p2_nx;
      starter_p2 <= starter_p2_nx;
      mover_p2   <= mover_p2_nx;
      p1_win     <= p1_win_nx;
      p2_win     <= p2_win_nx;
      grid_full  <= grid_full_nx;
      p1_score   <= p1_score_nx;
      p2_score   <= p2_score_nx;
    end
  end

  assign bus.p1_turn   = (state == P1_MOVE);
  assign bus.p2_turn   = (state == P2_MOVE);
  assign bus.p1_win    = p1_win;
  assign bus.p2_win    = p2_win;
  assign bus.grid_full = grid_full;
  assign bus.cell_p1   = cell_p1;
  assign bus.cell_p2   = cell_p2;
  assign bus.p1_score  = p1_score;
  assign bus.p2_score  = p2_score;

endmodule

// File: tb/tb_tic_tac_toe_nk.sv
// Bench for tic_tac_toe_nk (5x5, four in a row, 2-bit scores): a board-level
// game model predicts every settled output change; a monitor pops and compares.
module tb_tic_tac_toe_nk;

  localparam int N       = 5;
  localparam int K       = 4;
  localparam int SCORE_W = 2;
  localparam int CELLS   = N * N;
  localparam int SMAX    = (1 << SCORE_W) - 1;
  localparam int VW      = 2 * CELLS + 5 + 2 * SCORE_W;

  localparam int DRAW_X[13] = '{0, 1, 4, 7, 8, 10, 11, 14, 17, 18, 20, 21, 24};
  localparam int DRAW_O[12] = '{2, 3, 5, 6, 9, 12, 13, 15, 16, 19, 22, 23};
  localparam int WIN_X[13]  = '{0, 1, 4, 7, 8, 10, 11, 12, 17, 18, 20, 24, 13};
  localparam int WIN_O[12]  = '{2, 3, 5, 6, 9, 14, 15, 16, 19, 21, 22, 23};

  typedef struct {
    logic [VW-1:0] v;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  // Game model: 0 empty, 1 = P1, 2 = P2; m_over 0 playing, 1/2 winner, 3 draw.
  int board[CELLS];
  int m_turn, m_over, m_starter, m_s1, m_s2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tic_tac_toe_nk_if #(.N(N), .SCORE_W(SCORE_W)) bus ();

  tic_tac_toe_nk #(.N(N), .K(K), .SCORE_W(SCORE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [VW-1:0] dut_vec();
    return {bus.cell_p1, bus.cell_p2, bus.p1_turn, bus.p2_turn,
            bus.p1_win, bus.p2_win, bus.grid_full, bus.p1_score, bus.p2_score};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [CELLS-1:0] a, b;
    a = '0;
    b = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (board[i] == 1) a = a | (CELLS'(1) << i);
      if (board[i] == 2) b = b | (CELLS'(1) << i);
    end
    return {a, b, logic'(m_over == 0 && m_turn == 1), logic'(m_over == 0 && m_turn == 2),
            logic'(m_over == 1), logic'(m_over == 2), logic'(m_over == 3),
            SCORE_W'(m_s1), SCORE_W'(m_s2)};
  endfunction

  function automatic bit line_for(int p);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        for (int d = 0; d < 4; d++) begin
          int dr, dc, n;
          dr = (d == 0) ? 0 : 1;
          dc = (d == 0 || d == 2) ? 1 : ((d == 1) ? 0 : -1);
          n = 0;
          for (int i = 0; i < K; i++) begin
            int rr, cc;
            rr = r + i * dr;
            cc = c + i * dc;
            if (rr >= 0 && rr < N && cc >= 0 && cc < N && board[rr * N + cc] == p) n++;
          end
          if (n == K) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    foreach (board[i]) board[i] = 0;
    m_turn = 1; m_over = 0; m_starter = 1; m_s1 = 0; m_s2 = 0;
  endfunction

  function automatic void model_new_game();
    foreach (board[i]) board[i] = 0;
    m_over    = 0;
    m_starter = 3 - m_starter;
    m_turn    = m_starter;
  endfunction

  function automatic bit model_press(logic [CELLS-1:0] pat);
    int  idx;
    bit  empty_left;
    logic [CELLS-1:0] sh;
    idx = 0;
    if (m_over != 0 || $countones(pat) != 1) return 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      sh = pat >> i;
      if (sh[0]) idx = i;
    end
    if (board[idx] != 0) return 1'b0;
    board[idx] = m_turn;
    empty_left = 1'b0;
    foreach (board[i]) if (board[i] == 0) empty_left = 1'b1;
    if (line_for(m_turn)) begin
      m_over = m_turn;
      if (m_turn == 1 && m_s1 < SMAX) m_s1++;
      if (m_turn == 2 && m_s2 < SMAX) m_s2++;
    end else if (!empty_left) begin
      m_over = 3;
    end else begin
      m_turn = 3 - m_turn;
    end
    return 1'b1;
  endfunction

  task automatic check_now(input string name, input logic [VW-1:0] want);
    checks++;
    if (dut_vec() !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, dut_vec(), want);
    end
  endtask

  // Drive one button pattern and/or new_game for three cycles, then idle.
  task automatic act(input logic [CELLS-1:0] pat, input bit ng);
    int   c0;
    bit   acc;
    exp_t e;
    logic [2*CELLS+1:0] mid_want, mid_got;
    @(negedge clk);
    c0  = cyc;
    acc = 1'b0;
    if (ng) begin
      model_new_game();
      e.v = model_vec(); e.cyc = c0 + 2; q.push_back(e);
    end else begin
      acc = model_press(pat);
      if (acc) begin
        e.v = model_vec(); e.cyc = c0 + 3; q.push_back(e);
      end
    end
    bus.btn      = pat;
    bus.new_game = ng;
    repeat (2) @(negedge clk);
    if (acc) begin
      checks++;
      mid_want = {e.v[VW-1 -: 2*CELLS], 2'b00};
      mid_got  = {bus.cell_p1, bus.cell_p2, bus.p1_turn, bus.p2_turn};
      if (mid_got !== mid_want) begin
        errors++;
        $display("FAIL mark_latency: got %h, expected %h at cycle %0d", mid_got, mid_want, cyc);
      end
    end
    @(negedge clk);
    bus.btn      = '0;
    bus.new_game = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic mv(input int c);
    act(CELLS'(1) << c, 1'b0);
  endtask

  task automatic new_game();
    act('0, 1'b1);
  endtask

  task automatic fresh_p1();
    new_game();
    if (m_starter != 1) new_game();
  endtask

  task automatic apply_reset();
    exp_t e;
    bus.btn      = '0;
    bus.new_game = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_now("async_reset_clear", model_vec());
    repeat (3) @(negedge clk);
    e.v = model_vec(); e.cyc = -1; q.push_back(e);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every settled output change (CHECK transient skipped) pops one expectation.
  initial begin : monitor
    logic [VW-1:0] last, now;
    bit            armed, settled;
    exp_t          e;
    armed = 1'b1;
    last  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        armed = 1'b1;
        continue;
      end
      now     = dut_vec();
      settled = bus.p1_turn | bus.p2_turn | bus.p1_win | bus.p2_win | bus.grid_full;
      if (settled && (armed || now !== last)) begin
        armed = 1'b0;
        last  = now;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update: got %h at cycle %0d, expected no change", now, cyc);
        end else begin
          e = q.pop_front();
          if (now !== e.v || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL update: got %h at cycle %0d, expected %h at cycle %0d",
                     now, cyc, e.v, e.cyc);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int r, a, b;
    reset        = 1'b1;
    bus.btn      = '0;
    bus.new_game = 1'b0;
    #1;
    apply_reset();

    // P1 main diagonal 0,6,12,18; P2 holds only three in a row (1,2,3).
    mv(0); mv(1); mv(6); mv(2); mv(12); mv(3); mv(18);
    mv(5);
    // P2 starts next game and completes anti-diagonal 4,8,12,16.
    new_game();
    mv(4); mv(0); mv(8); mv(5); mv(12); mv(10); mv(16);
    mv(20);

    // Occupied cell, then two simultaneous presses, both ignored.
    new_game();
    mv(7); mv(7);
    act(CELLS'(3), 1'b0);
    check_now("p2_turn_held", model_vec());
    mv(9);
    // Mid-game restarts, the second one with a concurrent button edge.
    new_game();
    act(CELLS'(1) << 6, 1'b1);
    check_now("concurrent_move_dropped", model_vec());

    // Full-board draw, then full board whose last move wins.
    fresh_p1();
    for (int i = 0; i < 12; i++) begin mv(DRAW_X[i]); mv(DRAW_O[i]); end
    mv(DRAW_X[12]);
    fresh_p1();
    for (int i = 0; i < 12; i++) begin mv(WIN_X[i]); mv(WIN_O[i]); end
    mv(WIN_X[12]);

    // Reset mid-game clears scores and starter.
    fresh_p1();
    mv(0); mv(1);
    @(negedge clk);
    #3;
    apply_reset();

    // Five quick P1 wins saturate the 2-bit score.
    for (int g = 0; g < 5; g++) begin
      fresh_p1();
      mv(0); mv(5); mv(1); mv(6); mv(2); mv(7); mv(3);
    end

    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 99);
      a = $urandom_range(0, CELLS - 1);
      b = (a + $urandom_range(1, CELLS - 1)) % CELLS;
      if (m_over != 0 && r < 60)  new_game();
      else if (r < 80)            mv(a);
      else if (r < 88)            act((CELLS'(1) << a) | (CELLS'(1) << b), 1'b0);
      else if (r < 93)            new_game();
      else if (r < 96)            act(CELLS'(1) << a, 1'b1);
      else                        act('0, 1'b0);
    end

    for (int w = 0; w < 40 && q.size() != 0; w++) @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_update: got no change, expected %h at cycle %0d", e.v, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
